// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

  typedef enum logic [1:0] {SZ_8, SZ_16, SZ_32, SZ_64} size_t;

  localparam int unsigned MAX_ADDR = 128;

  // Sizes 4..7 collapse onto the widest access.
  function automatic size_t clamp_size(input logic [2:0] s);
    return s[2] ? SZ_64 : size_t'(s[1:0]);
  endfunction

  function automatic logic [MAX_ADDR-1:0] line_mask(input int unsigned offwidth);
    return {MAX_ADDR{1'b1}} << offwidth;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set age-based LRU tracker; age WAYS-1 marks the replacement victim.
module cache_lru
  import cache_pkg::*;
#(
  parameter int unsigned NUMSETS = 256,
  parameter int unsigned WAYS    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       touch,
  input  logic [$clog2(NUMSETS)-1:0] idx,
  input  logic [$clog2(WAYS)-1:0]    way,
  output logic [$clog2(WAYS)-1:0]    victim
);

  localparam int unsigned WAYW = $clog2(WAYS);

  logic [WAYW-1:0] age [NUMSETS][WAYS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < NUMSETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          age[s][w] <= WAYW'(w);
    end else if (touch) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAYW'(w) == way)
          age[idx][w] <= '0;
        else if (age[idx][w] < age[idx][way])
          age[idx][w] <= age[idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int unsigned w = 0; w < WAYS; w++)
      if (age[idx][w] == WAYW'(WAYS - 1)) victim = WAYW'(w);
  end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back, write-allocate cache with LRU replacement
// and a level-held request / single-cycle-ack memory handshake.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDRESSSIZE = 64,
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned BLOCKSZ     = 512,
  parameter int unsigned NUMSETS     = 256,
  parameter int unsigned WAYS        = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   wr_en,
  input  logic [ADDRESSSIZE-1:0] addr,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [2:0]             data_size,
  output logic [WIDTH-1:0]       data_out,
  output logic                   operation_complete,
  output logic                   busy,
  output logic [ADDRESSSIZE-1:0] mem_address,
  output logic [BLOCKSZ-1:0]     mem_data_out,
  output logic                   mem_wr_en,
  output logic                   mem_req,
  input  logic [BLOCKSZ-1:0]     mem_data_in,
  input  logic                   mem_data_valid
);

  localparam int unsigned OFFWIDTH = $clog2(BLOCKSZ / 8);
  localparam int unsigned IDXWIDTH = $clog2(NUMSETS);
  localparam int unsigned TAGWIDTH = ADDRESSSIZE - IDXWIDTH - OFFWIDTH;
  localparam int unsigned WAYW     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned WBYTES   = WIDTH / 8;
  localparam logic [ADDRESSSIZE-1:0] LINE_MASK = ADDRESSSIZE'(line_mask(OFFWIDTH));

  state_t                 state;
  logic [ADDRESSSIZE-1:0] req_addr;
  logic                   req_wr;
  logic [WIDTH-1:0]       req_data;
  size_t                  req_size;
  logic [WAYW-1:0]        req_way;

  logic [BLOCKSZ-1:0]  data_arr [WAYS][NUMSETS];
  logic [TAGWIDTH-1:0] tag_arr  [WAYS][NUMSETS];
  logic [NUMSETS-1:0]  valid    [WAYS];
  logic [NUMSETS-1:0]  dirty    [WAYS];

  logic [IDXWIDTH-1:0] idx;
  logic [TAGWIDTH-1:0] tag;
  logic [OFFWIDTH-1:0] off;
  int unsigned         nbytes;
  logic                hit;
  logic [WAYW-1:0]     hit_way;
  logic [WAYW-1:0]     victim;
  logic [WAYW-1:0]     lru_victim;
  logic [BLOCKSZ-1:0]  merged;
  logic [WIDTH-1:0]    load_val;
  logic [OFFWIDTH-1:0] bi;

  assign idx    = req_addr[IDXWIDTH+OFFWIDTH-1:OFFWIDTH];
  assign tag    = req_addr[ADDRESSSIZE-1 -: TAGWIDTH];
  assign nbytes = 32'd1 << req_size;
  assign off    = req_addr[OFFWIDTH-1:0] & ~OFFWIDTH'(nbytes - 1);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++)
      if (valid[w][idx] && tag_arr[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
  end

  // Lowest-index invalid way wins over the LRU choice.
  always_comb begin
    victim = lru_victim;
    for (int w = int'(WAYS) - 1; w >= 0; w--)
      if (!valid[w][idx]) victim = WAYW'(w);
  end

  always_comb begin
    merged   = data_arr[hit_way][idx];
    load_val = '0;
    bi       = '0;
    for (int unsigned i = 0; i < WBYTES; i++) begin
      if (i < nbytes) begin
        bi = off + OFFWIDTH'(i);
        merged[bi*8 +: 8]  = req_data[i*8 +: 8];
        load_val[i*8 +: 8] = data_arr[req_way][idx][bi*8 +: 8];
      end
    end
  end

  if (WAYS > 1) begin : g_lru
    cache_lru #(.NUMSETS(NUMSETS), .WAYS(WAYS)) u_lru (
      .clk    (clk),
      .rst    (rst),
      .touch  (state == LOOKUP && hit),
      .idx    (idx),
      .way    (hit_way),
      .victim (lru_victim)
    );
  end else begin : g_no_lru
    assign lru_victim = '0;
  end

  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && req_wr) begin
      data_arr[hit_way][idx] <= merged;
    end else if (state == FILL && mem_data_valid) begin
      data_arr[req_way][idx] <= mem_data_in;
      tag_arr[req_way][idx]  <= tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      req_addr           <= '0;
      req_wr             <= 1'b0;
      req_data           <= '0;
      req_size           <= SZ_8;
      req_way            <= '0;
      data_out           <= '0;
      operation_complete <= 1'b0;
      busy               <= 1'b0;
      mem_req            <= 1'b0;
      mem_wr_en          <= 1'b0;
      mem_address        <= '0;
      mem_data_out       <= '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
    end else begin
      operation_complete <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          req_addr <= addr;
          req_wr   <= wr_en;
          req_data <= data_in;
          req_size <= clamp_size(data_size);
          busy     <= 1'b1;
          state    <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          req_way <= hit_way;
          if (req_wr) dirty[hit_way][idx] <= 1'b1;
          state <= RESPOND;
        end else begin
          req_way <= victim;
          mem_req <= 1'b1;
          if (valid[victim][idx] && dirty[victim][idx]) begin
            mem_wr_en    <= 1'b1;
            mem_address  <= {tag_arr[victim][idx], idx, OFFWIDTH'(0)};
            mem_data_out <= data_arr[victim][idx];
            state        <= WRITEBACK;
          end else begin
            mem_wr_en   <= 1'b0;
            mem_address <= req_addr & LINE_MASK;
            state       <= FILL;
          end
        end
        WRITEBACK: if (mem_data_valid) begin
          mem_wr_en   <= 1'b0;
          mem_address <= req_addr & LINE_MASK;
          state       <= FILL;
        end
        FILL: if (mem_data_valid) begin
          valid[req_way][idx] <= 1'b1;
          dirty[req_way][idx] <= 1'b0;
          mem_req      <= 1'b0;
          mem_address  <= '0;
          mem_data_out <= '0;
          state        <= LOOKUP;
        end
        RESPOND: begin
          if (!req_wr) data_out <= load_val;
          operation_complete <= 1'b1;
          busy               <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: a recency-list / byte-array cache model plus
// a sparse backing memory predicts every transaction; a negedge monitor compares.
module tb_assoc_cache;

  localparam int SETS = 256;
  localparam int NW   = 2;
  localparam int LB   = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable, wr_en;
  logic [63:0]  addr, data_in;
  logic [2:0]   data_size;
  logic [63:0]  data_out;
  logic         operation_complete, busy;
  logic [63:0]  mem_address;
  logic [511:0] mem_data_out;
  logic         mem_wr_en, mem_req;
  logic [511:0] mem_data_in;
  logic         mem_data_valid;

  assoc_cache #(.ADDRESSSIZE(64), .WIDTH(64), .BLOCKSZ(512), .NUMSETS(256), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .addr(addr),
    .data_in(data_in), .data_size(data_size), .data_out(data_out),
    .operation_complete(operation_complete), .busy(busy),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_wr_en(mem_wr_en),
    .mem_req(mem_req), .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int accepted = 0, done_count = 0, wb_obs = 0, fill_obs = 0;
  bit chk_en = 0, active = 0;
  int edges_since = -1, exp_done_at = 1000, exp_phase = 0;
  logic [63:0]  last_wb_addr, last_fill_addr;
  logic [511:0] last_wb_data;

  bit           exp_hit, exp_wb, exp_load;
  logic [63:0]  exp_wb_addr, exp_fill_addr, exp_data;
  logic [511:0] exp_wb_line, exp_fill_line;

  // Model state: MRU-first recency list per set, bytes per line.
  logic [7:0]   m_data  [SETS][NW][LB];
  logic [49:0]  m_tag   [SETS][NW];
  bit           m_valid [SETS][NW];
  bit           m_dirty [SETS][NW];
  int           m_order [SETS][$];
  logic [511:0] mem_store [logic [63:0]];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges_since++;
  endtask

  function automatic logic [511:0] mem_line(input logic [63:0] la);
    logic [511:0] l;
    if (mem_store.exists(la)) return mem_store[la];
    for (int i = 0; i < LB; i++) l[i*8 +: 8] = 8'(i) + 8'(la[21:14] << 4);
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int k = 0; k < NW; k++) begin
        m_valid[s][k] = 0;
        m_dirty[s][k] = 0;
      end
      m_order[s] = '{0, 1};
    end
  endtask

  task automatic predict(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [2:0] sz);
    int set, way, nb, off;
    logic [49:0] t;
    logic [511:0] l;
    set = int'(a[13:6]);
    t = a[63:14];
    way = -1;
    for (int k = 0; k < NW; k++) if (m_valid[set][k] && m_tag[set][k] == t) way = k;
    exp_hit = (way >= 0);
    exp_wb = 0;
    if (way < 0) begin
      for (int k = NW - 1; k >= 0; k--) if (!m_valid[set][k]) way = k;
      if (way < 0) way = m_order[set][m_order[set].size() - 1];
      if (m_valid[set][way] && m_dirty[set][way]) begin
        exp_wb = 1;
        exp_wb_addr = {m_tag[set][way], a[13:6], 6'b0};
        for (int i = 0; i < LB; i++) l[i*8 +: 8] = m_data[set][way][i];
        exp_wb_line = l;
        mem_store[exp_wb_addr] = l;
      end
      exp_fill_addr = {a[63:6], 6'b0};
      exp_fill_line = mem_line(exp_fill_addr);
      for (int i = 0; i < LB; i++) m_data[set][way][i] = exp_fill_line[i*8 +: 8];
      m_valid[set][way] = 1;
      m_dirty[set][way] = 0;
      m_tag[set][way] = t;
    end
    for (int k = 0; k < m_order[set].size(); k++)
      if (m_order[set][k] == way) begin
        m_order[set].delete(k);
        break;
      end
    m_order[set].push_front(way);
    nb = 1 << ((sz > 3'd3) ? 3 : int'(sz));
    off = (int'(a[5:0]) / nb) * nb;
    exp_load = !w;
    exp_data = '0;
    for (int i = 0; i < nb; i++) begin
      if (w) begin
        m_data[set][way][off + i] = d[i*8 +: 8];
        m_dirty[set][way] = 1;
      end else begin
        exp_data[i*8 +: 8] = m_data[set][way][off + i];
      end
    end
  endtask

  // Memory side answers after the request has been held for two cycles.
  task automatic request(input logic [63:0] a, input logic w, input logic [63:0] d,
                         input logic [2:0] sz, input bit noise);
    int budget, lat;
    bit vld_now;
    budget = 0;
    lat = 0;
    predict(a, w, d, sz);
    addr = a; wr_en = w; data_in = d; data_size = sz; enable = 1'b1;
    active = 1; edges_since = -1; exp_done_at = exp_hit ? 2 : 1000; exp_phase = 0;
    accepted++;
    step();
    enable = 1'b0;
    exp_phase = exp_wb ? 1 : (exp_hit ? 0 : 2);
    while (edges_since != exp_done_at) begin
      budget++;
      if (budget > 80) begin
        check("request_timeout", 1'b1, 1'b0);
        break;
      end
      if (noise) begin
        enable = 1'($urandom_range(0, 1));
        wr_en = 1'($urandom_range(0, 1));
        addr = {$urandom(), $urandom()};
        data_in = {$urandom(), $urandom()};
        data_size = 3'($urandom_range(0, 7));
      end
      vld_now = 0;
      if (exp_phase != 0 && mem_req) begin
        lat++;
        if (lat >= 2) begin
          mem_data_valid = 1'b1;
          mem_data_in = (exp_phase == 2) ? exp_fill_line : '0;
          vld_now = 1;
        end
      end
      step();
      if (vld_now) begin
        mem_data_valid = 1'b0;
        lat = 0;
        if (exp_phase == 1) exp_phase = 2;
        else begin
          exp_phase = 0;
          exp_done_at = edges_since + 2;
        end
      end
    end
    enable = 1'b0;
    step();
    active = 0;
    exp_phase = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit xbusy, xdone;
      xbusy = active && edges_since >= 0 && edges_since < exp_done_at;
      xdone = active && edges_since == exp_done_at;
      check("busy", busy, xbusy);
      check("operation_complete", operation_complete, xdone);
      if (operation_complete) begin
        done_count++;
        if (xdone && exp_load) check("data_out", data_out, exp_data);
      end
      if (exp_phase == 0) begin
        check("mem_req_idle", mem_req, 1'b0);
      end else if (mem_req) begin
        if (exp_phase == 1) begin
          wb_obs++;
          check("wb_wr_en", mem_wr_en, 1'b1);
          check("wb_address", mem_address, exp_wb_addr);
          check("wb_data", mem_data_out, exp_wb_line);
          last_wb_addr = mem_address;
          last_wb_data = mem_data_out;
        end else begin
          fill_obs++;
          check("fill_wr_en", mem_wr_en, 1'b0);
          check("fill_address", mem_address, exp_fill_addr);
          last_fill_addr = mem_address;
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data_out"}, data_out, '0);
    check({tag, "_complete"}, operation_complete, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_wr_en"}, mem_wr_en, 1'b0);
    check({tag, "_mem_address"}, mem_address, '0);
    check({tag, "_mem_data_out"}, mem_data_out, '0);
  endtask

  initial begin
    int n, snap;
    rst = 1'b0; enable = 0; wr_en = 0; addr = '0; data_in = '0; data_size = '0;
    mem_data_in = '0; mem_data_valid = 0;
    model_reset();
    step();
    step();
    check_outputs_zero("reset");
    rst = 1'b1;
    step();
    chk_en = 1;

    request(64'h1000, 0, '0, 3'd3, 0);
    check("pin_first_load", data_out, 64'h0706050403020100);
    check("pin_first_fill_addr", last_fill_addr, 64'h1000);
    snap = fill_obs;
    request(64'h1000, 0, '0, 3'd3, 0);
    check("hit_no_fill", fill_obs, snap);

    request(64'h1003, 1, 64'hAB, 3'd0, 0);
    request(64'h1000, 0, '0, 3'd3, 0);
    check("pin_after_store", data_out, 64'h07060504AB020100);
    request(64'h1004, 0, '0, 3'd2, 0);
    check("pin_load4", data_out, 64'h0000000007060504);
    check("store_path_no_fill", fill_obs, snap);
    request(64'h1003, 0, '0, 3'd1, 0);
    check("pin_load2_aligned", data_out, 64'h000000000000AB02);
    request(64'h1005, 0, '0, 3'd7, 0);
    check("pin_size7_as_8B", data_out, 64'h07060504AB020100);

    request(64'h1000, 0, '0, 3'd3, 0);
    request(64'h5000, 0, '0, 3'd3, 0);
    request(64'h1000, 0, '0, 3'd3, 0);
    snap = wb_obs;
    request(64'h9000, 0, '0, 3'd3, 0);
    check("clean_evict_no_wb", wb_obs, snap);
    snap = fill_obs;
    request(64'h1000, 0, '0, 3'd3, 0);
    check("reload_1000_hits", fill_obs, snap);

    request(64'h5000, 1, 64'hDEADBEEF00000000, 3'd3, 0);
    request(64'h1000, 0, '0, 3'd3, 0);
    request(64'h9000, 0, '0, 3'd3, 0);
    check("pin_wb_addr", last_wb_addr, 64'h5000);
    check("pin_wb_bytes", last_wb_data[63:0], 64'hDEADBEEF00000000);
    check("pin_fill_after_wb", last_fill_addr, 64'h9000);

    request(64'h1000, 1, 64'h1234, 3'd1, 1);
    request(64'hD000, 0, '0, 3'd3, 1);
    request(64'h1000, 0, '0, 3'd3, 1);
    check("done_per_request", done_count, accepted);

    // Abort an in-flight fill with reset; the response is never delivered.
    predict(64'h20000, 0, '0, 3'd3);
    addr = 64'h20000; wr_en = 0; data_size = 3'd3; enable = 1'b1;
    active = 1; edges_since = -1; exp_done_at = 1000; exp_phase = 0;
    step();
    enable = 1'b0;
    exp_phase = 2;
    n = 0;
    while (!mem_req && n < 10) begin
      step();
      n++;
    end
    check("fill_before_reset", mem_req, 1'b1);
    step();
    chk_en = 0;
    rst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    active = 0;
    exp_phase = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_en = 1;
    snap = fill_obs;
    request(64'h1000, 0, '0, 3'd3, 0);
    check("miss_after_reset", fill_obs > snap, 1'b1);
    check("pin_load_after_reset", data_out, 64'h0706050403020100);
    check("done_total", done_count, accepted);

    step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
